// File: rtl/demod_nco.sv
// demod_nco: phase accumulator plus registered quadrature cos/sin LUT for the carrier path.
// Optional phase_o debug output is enabled by defining DEMOD_NCO_PHASE_OUT_EN.
module demod_nco #(
    parameter int PHASE_W = 16,
    parameter int LUT_AW  = 3,
    parameter int OUT_W   = 8,
    parameter logic [PHASE_W-1:0] DEF_FCW = PHASE_W'(1) << (PHASE_W - LUT_AW)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     fcw_ld,
    input  logic [PHASE_W-1:0]       fcw_in,
    input  logic                     sync,
    input  logic                     v,
    output logic signed [OUT_W-1:0]  cos,
    output logic signed [OUT_W-1:0]  sin,
`ifdef DEMOD_NCO_PHASE_OUT_EN
    output logic [LUT_AW-1:0]        phase_o,
`endif
    output logic                     valid
);

    localparam int N = 1 << LUT_AW;

    // Integer Taylor series in Q30 over one quadrant, folded by symmetry.
    function automatic logic signed [OUT_W-1:0] lut_cos(input int k);
        longint th;
        longint x2;
        longint term;
        longint c;
        longint s;
        longint val;
        longint lim;
        longint half;
        longint one;
        int     q;
        int     r;
        q    = k / (N / 4);
        r    = k % (N / 4);
        one  = 64'sd1 <<< 30;
        half = 64'sd1 <<< 29;
        th   = (64'sd6746518852 * longint'(r)) / longint'(N);
        x2   = (th * th) >>> 30;
        c    = one;
        term = one;
        for (int n = 1; n <= 10; n++) begin
            term = -((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n));
            c    = c + term;
        end
        s    = th;
        term = th;
        for (int n = 1; n <= 10; n++) begin
            term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
            s    = s + term;
        end
        case (q)
            0:       val = c;
            1:       val = -s;
            2:       val = -c;
            default: val = s;
        endcase
        val = val * (64'sd1 <<< (OUT_W - 1));
        if (val >= 64'sd0) val = (val + half) / one;
        else               val = (val - half) / one;
        lim = 64'sd1 <<< (OUT_W - 1);
        if (val > lim - 64'sd1) val = lim - 64'sd1;
        if (val < -lim)         val = -lim;
        return OUT_W'(val);
    endfunction

    logic signed [OUT_W-1:0] cos_lut [N];
    logic signed [OUT_W-1:0] sin_lut [N];

    for (genvar k = 0; k < N; k++) begin : g_lut
        localparam int KS = (k + N - N / 4) % N;
        localparam logic signed [OUT_W-1:0] CV = lut_cos(k);
        localparam logic signed [OUT_W-1:0] SV = lut_cos(KS);
        assign cos_lut[k] = CV;
        assign sin_lut[k] = SV;
    end

    logic [PHASE_W-1:0]      acc_q;
    logic [PHASE_W-1:0]      acc_d;
    logic [PHASE_W-1:0]      fcw_q;
    logic [PHASE_W-1:0]      fcw_d;
    logic [LUT_AW-1:0]       addr_q;
    logic [LUT_AW-1:0]       addr_d;
    logic                    vld_q;
    logic signed [OUT_W-1:0] cos_q;
    logic signed [OUT_W-1:0] sin_q;
    logic                    valid_q;

    always_comb begin
        acc_d = acc_q;
        if (sync) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + fcw_q;
        end
        fcw_d  = fcw_ld ? fcw_in : fcw_q;
        addr_d = acc_q[PHASE_W-1 -: LUT_AW] + LUT_AW'(v);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            fcw_q <= DEF_FCW;
        end else begin
            acc_q <= acc_d;
            fcw_q <= fcw_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            vld_q  <= en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cos_q   <= '0;
            sin_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            cos_q   <= cos_lut[addr_q];
            sin_q   <= sin_lut[addr_q];
            valid_q <= vld_q;
        end
    end

`ifdef DEMOD_NCO_PHASE_OUT_EN
    logic [LUT_AW-1:0] phase_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= addr_q;
        end
    end

    assign phase_o = phase_q;
`endif

    assign cos   = cos_q;
    assign sin   = sin_q;
    assign valid = valid_q;

endmodule
